// File: rtl/dct_pkg.sv
// Shared types, cosine ROM and fixed-point helpers for the 8x8 DCT engine.
// Optional bypass path is enabled by defining DCT_BYPASS_EN.
package dct_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROW,
    COL,
    OUT
  } state_t;

  localparam int N = 8;

  typedef logic [63:0][31:0] rom_t;

  function automatic int x_width(int in_w);
    return in_w + 1;
  endfunction

  function automatic int t_width(int in_w);
    return in_w + 4;
  endfunction

  function automatic int c_width(int frac);
    return frac + 2;
  endfunction

  function automatic int acc_width(int in_w, int frac);
    return t_width(in_w) + c_width(frac) + 3;
  endfunction

  function automatic real cos16(int m);
    case (m)
      0: return 1.0;
      1: return 0.98078528040323043;
      2: return 0.92387953251128674;
      3: return 0.83146961230254524;
      4: return 0.70710678118654752;
      5: return 0.55557023301960218;
      6: return 0.38268343236508977;
      7: return 0.19509032201612827;
      default: return 0.0;
    endcase
  endfunction

  // cos(m*pi/16) folded onto the first quadrant
  function automatic rom_t cos_rom(int frac);
    rom_t rom;
    real v;
    int m;
    rom = '0;
    for (int u = 0; u < N; u++) begin
      for (int x = 0; x < N; x++) begin
        m = ((2 * x + 1) * u) % 32;
        if (m <= 8) v = cos16(m);
        else if (m <= 16) v = -cos16(16 - m);
        else if (m <= 24) v = -cos16(m - 16);
        else v = cos16(32 - m);
        v = v * ((u == 0) ? 0.35355339059327376 : 0.5);
        v = v * real'(1 << frac);
        rom[u*N+x] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      end
    end
    return rom;
  endfunction

  function automatic logic signed [63:0] round_shift(
    logic signed [63:0] v,
    int s
  );
    if (s == 0) return v;
    return (v + (64'sd1 <<< (s - 1))) >>> s;
  endfunction

  function automatic logic signed [63:0] saturate(
    logic signed [63:0] v,
    int w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dct2d_8x8_engine_dot.sv
// Combinational 8-tap signed dot product with round-half-up shift.
// Shared by the row and column passes of the DCT engine.
module dct8_dot
  import dct_pkg::*;
#(
  parameter int AW = 12,
  parameter int BW = 14,
  parameter int OW = 29
) (
  input  logic [N*AW-1:0]     a,
  input  logic [N*BW-1:0]     b,
  input  logic [5:0]          shift,
  output logic signed [OW-1:0] y
);

  logic signed [OW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc
          + OW'(signed'(a[i*AW +: AW]))
          * OW'(signed'(b[i*BW +: BW]));
    end
    y = OW'(round_shift(64'(acc), int'(shift)));
  end

endmodule

// File: rtl/dct2d_8x8_engine.sv
// Separable 8x8 DCT-II: row pass then column pass, one element per cycle.
// Define DCT_BYPASS_EN to add the level-shift-only bypass path.
module dct2d_8x8_engine
  import dct_pkg::*;
#(
  parameter int IN_WIDTH     = 8,
  parameter int COEF_FRAC    = 12,
  parameter int OUT_WIDTH    = 16,
  parameter int OUTPUT_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [64*IN_WIDTH-1:0]  block_in,
  input  logic                    block_valid,
  output logic                    block_ready,
  output logic [64*OUT_WIDTH-1:0] dct_out,
  output logic                    dct_valid,
  input  logic                    dct_ready,
  output logic                    busy
`ifdef DCT_BYPASS_EN
  ,
  input  logic                    bypass
`endif
);

  localparam int XW = x_width(IN_WIDTH);
  localparam int TW = t_width(IN_WIDTH);
  localparam int CW = c_width(COEF_FRAC);
  localparam int AW = acc_width(IN_WIDTH, COEF_FRAC);
  localparam rom_t ROM = cos_rom(COEF_FRAC);
  localparam logic [XW-1:0] LVL = XW'(1) << (IN_WIDTH - 1);

  state_t state;
  logic [5:0] k;
  logic [2:0] hi;
  logic [2:0] lo;
  logic signed [XW-1:0] xb [64];
  logic signed [TW-1:0] tb [64];
  logic signed [XW-1:0] lvl [64];

  logic [N*TW-1:0] dot_a;
  logic [N*CW-1:0] dot_b;
  logic [5:0] dot_s;
  logic signed [AW-1:0] dot_y;

  assign hi = k[5:3];
  assign lo = k[2:0];
  assign block_ready = (state == IDLE) && enable;
  assign busy = (state != IDLE);

  always_comb begin
    for (int i = 0; i < 64; i++) begin
      lvl[i] = {1'b0, block_in[i*IN_WIDTH +: IN_WIDTH]} - LVL;
    end
  end

  // Row pass reads X[r][*], column pass reads T[*][v]
  always_comb begin
    dot_a = '0;
    dot_b = '0;
    dot_s = 6'(COEF_FRAC);
    for (int i = 0; i < N; i++) begin
      dot_b[i*CW +: CW] = ROM[{lo, 3'(i)}][CW-1:0];
      if (state == COL) dot_a[i*TW +: TW] = tb[{3'(i), hi}];
      else dot_a[i*TW +: TW] = TW'(xb[{hi, 3'(i)}]);
    end
    if (state == COL) dot_s = 6'(COEF_FRAC + OUTPUT_SHIFT);
  end

  dct8_dot #(
    .AW(TW),
    .BW(CW),
    .OW(AW)
  ) u_dot (
    .a(dot_a),
    .b(dot_b),
    .shift(dot_s),
    .y(dot_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      dct_valid <= 1'b0;
      dct_out <= '0;
      for (int i = 0; i < 64; i++) begin
        xb[i] <= '0;
        tb[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (block_valid && block_ready) begin
            for (int i = 0; i < 64; i++) xb[i] <= lvl[i];
            k <= '0;
            state <= ROW;
`ifdef DCT_BYPASS_EN
            if (bypass) begin
              for (int i = 0; i < 64; i++) begin
                dct_out[i*OUT_WIDTH +: OUT_WIDTH] <= OUT_WIDTH'(lvl[i]);
              end
              dct_valid <= 1'b1;
              state <= OUT;
            end
`endif
          end
        end
        ROW: begin
          if (enable) begin
            tb[k] <= TW'(dot_y);
            k <= k + 6'd1;
            if (k == 6'd63) state <= COL;
          end
        end
        COL: begin
          if (enable) begin
            dct_out[{lo, hi}*OUT_WIDTH +: OUT_WIDTH] <=
              OUT_WIDTH'(saturate(64'(dot_y), OUT_WIDTH));
            k <= k + 6'd1;
            if (k == 6'd63) begin
              state <= OUT;
              dct_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (dct_ready) begin
            dct_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct2d_8x8_engine.sv
// Directed self-checking bench for dct2d_8x8_engine (default and saturating builds).
module tb_dct2d_8x8_engine;

  localparam real PI = 3.14159265358979324;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic [511:0] block_in = '0;
  logic block_valid = 1'b0;
  logic block_ready;
  logic [1023:0] dct_out;
  logic dct_valid;
  logic dct_ready = 1'b0;
  logic busy;
`ifdef DCT_BYPASS_EN
  logic bypass = 1'b0;
`endif

  logic [511:0] s_in = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [639:0] s_out;
  logic s_dv;
  logic s_dr = 1'b0;
  logic s_busy;
`ifdef DCT_BYPASS_EN
  logic s_bypass = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  real gold [64];

  always #5 clk = ~clk;

  dct2d_8x8_engine dut (
    .clk(clk), .rst(rst), .enable(enable),
    .block_in(block_in), .block_valid(block_valid),
    .block_ready(block_ready), .dct_out(dct_out),
    .dct_valid(dct_valid), .dct_ready(dct_ready), .busy(busy)
`ifdef DCT_BYPASS_EN
    , .bypass(bypass)
`endif
  );

  dct2d_8x8_engine #(.OUT_WIDTH(10), .OUTPUT_SHIFT(0)) dut_s (
    .clk(clk), .rst(rst), .enable(enable),
    .block_in(s_in), .block_valid(s_valid),
    .block_ready(s_ready), .dct_out(s_out),
    .dct_valid(s_dv), .dct_ready(s_dr), .busy(s_busy)
`ifdef DCT_BYPASS_EN
    , .bypass(s_bypass)
`endif
  );

  function automatic int coef(int i);
    return int'(signed'(dct_out[i*16 +: 16]));
  endfunction

  function automatic logic [511:0] flat(int p);
    logic [511:0] b;
    for (int i = 0; i < 64; i++) b[i*8 +: 8] = 8'(p);
    return b;
  endfunction

  function automatic logic [511:0] pattern(int sel);
    logic [511:0] b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[(r*8+c)*8 +: 8] = (sel == 0) ? 8'(r*30 + c*3)
                                       : 8'((r*37 + c*91 + r*c*11) % 256);
    return b;
  endfunction

  task automatic compute_gold(input logic [511:0] blk);
    real s, au, av;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        s = 0.0;
        au = (u == 0) ? $sqrt(0.125) : 0.5;
        av = (v == 0) ? $sqrt(0.125) : 0.5;
        for (int x = 0; x < 8; x++)
          for (int y = 0; y < 8; y++)
            s += (real'(int'(blk[(x*8+y)*8 +: 8])) - 128.0)
               * $cos(real'((2*x+1)*u) * PI / 16.0)
               * $cos(real'((2*y+1)*v) * PI / 16.0);
        gold[u*8+v] = au * av * s / 16.0;
      end
  endtask

  task automatic accept(input logic [511:0] blk);
    int n;
    block_in = blk;
    block_valid = 1'b1;
    n = 0;
    while (!block_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (block_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: block_ready=%b required 1", block_ready);
    end
    @(posedge clk); #1;
    block_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (dct_valid !== 1'b1 && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    dct_ready = 1'b1;
    @(posedge clk); #1;
    dct_ready = 1'b0;
  endtask

  task automatic check_gold(input string name);
    real d;
    for (int i = 0; i < 64; i++) begin
      d = real'(coef(i)) - gold[i];
      checks++;
      if (d > 1.0 || d < -1.0) begin
        errors++;
        $display("FAIL %s F[%0d]: got %0d required %f +-1", name, i, coef(i), gold[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks += 4;
    if (dct_valid !== 1'b0) begin errors++; $display("FAIL reset dct_valid: got %b required 0", dct_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    if (dct_out !== '0) begin errors++; $display("FAIL reset dct_out: got %h required 0", dct_out); end
    if (block_ready !== 1'b1) begin errors++; $display("FAIL reset block_ready: got %b required 1", block_ready); end
  endtask

  task automatic test_dc(input int pix, input int f00);
    int lat;
    accept(flat(pix));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL dc%0d busy: got %b required 1", pix, busy); end
    wait_valid(lat);
    checks++;
    if (lat !== 128) begin errors++; $display("FAIL dc%0d latency: got %0d required 128", pix, lat); end
    checks++;
    if (coef(0) < f00 - 1 || coef(0) > f00 + 1) begin
      errors++;
      $display("FAIL dc%0d F00: got %0d required %0d +-1", pix, coef(0), f00);
    end
    for (int i = 1; i < 64; i++) begin
      checks++;
      if (coef(i) !== 0) begin
        errors++;
        $display("FAIL dc%0d AC[%0d]: got %0d required 0", pix, i, coef(i));
      end
    end
    release_out();
  endtask

  task automatic test_pattern(input int sel);
    int lat;
    compute_gold(pattern(sel));
    accept(pattern(sel));
    wait_valid(lat);
    checks++;
    if (lat !== 128) begin errors++; $display("FAIL pattern%0d latency: got %0d required 128", sel, lat); end
    check_gold($sformatf("pattern%0d", sel));
    release_out();
  endtask

  task automatic test_saturate();
    int pix [2] = '{255, 0};
    int exp [2] = '{511, -512};
    int n;
    for (int t = 0; t < 2; t++) begin
      s_in = flat(pix[t]);
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 300) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      s_valid = 1'b0;
      n = 0;
      while (s_dv !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      checks += 2;
      if (n !== 128) begin errors++; $display("FAIL sat%0d latency: got %0d required 128", pix[t], n); end
      if (int'(signed'(s_out[9:0])) !== exp[t]) begin
        errors++;
        $display("FAIL sat%0d F00: got %0d required %0d", pix[t], int'(signed'(s_out[9:0])), exp[t]);
      end
      s_dr = 1'b1;
      @(posedge clk); #1;
      s_dr = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    compute_gold(pattern(1));
    accept(pattern(1));
    wait_valid(lat);
    block_in = flat(10);
    block_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (dct_valid !== 1'b1 || block_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold cycle %0d: valid=%b ready=%b busy=%b required 1 0 1", c, dct_valid, block_ready, busy);
      end
      check_gold("hold");
      @(posedge clk); #1;
    end
    release_out();
    checks += 3;
    if (block_ready !== 1'b1) begin errors++; $display("FAIL post-handshake block_ready: got %b required 1", block_ready); end
    if (dct_valid !== 1'b0) begin errors++; $display("FAIL post-handshake dct_valid: got %b required 0", dct_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL post-handshake busy: got %b required 0", busy); end
    block_valid = 1'b0;
  endtask

  task automatic test_enable_stall();
    int lat;
    compute_gold(pattern(0));
    accept(pattern(0));
    repeat (5) begin @(posedge clk); #1; end
    enable = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    enable = 1'b1;
    wait_valid(lat);
    checks++;
    if (lat + 15 !== 138) begin errors++; $display("FAIL stall latency: got %0d required 138", lat + 15); end
    check_gold("stall");
    release_out();
  endtask

  task automatic test_reset_mid();
    int lat;
    accept(pattern(1));
    repeat (70) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 4;
    if (dct_valid !== 1'b0) begin errors++; $display("FAIL midrst dct_valid: got %b required 0", dct_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b required 0", busy); end
    if (dct_out !== '0) begin errors++; $display("FAIL midrst dct_out: got %h required 0", dct_out); end
    if (block_ready !== 1'b1) begin errors++; $display("FAIL midrst block_ready: got %b required 1", block_ready); end
    test_dc(255, 64);
  endtask

`ifdef DCT_BYPASS_EN
  task automatic test_bypass();
    int lat;
    bypass = 1'b1;
    accept(flat(200));
    bypass = 1'b0;
    lat = 1;
    checks++;
    if (dct_valid !== 1'b1) begin errors++; $display("FAIL bypass latency: dct_valid=%b required 1 one edge after accept", dct_valid); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (coef(i) !== 72) begin errors++; $display("FAIL bypass F[%0d]: got %0d required 72", i, coef(i)); end
    end
    release_out();
  endtask
`endif

  initial begin
    test_reset();
    test_dc(128, 0);
    test_dc(255, 64);
    test_dc(0, -64);
    test_pattern(0);
    test_pattern(1);
    test_saturate();
    test_backpressure();
    test_enable_stall();
    test_reset_mid();
`ifdef DCT_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
